// File: rtl/adc_stream_pkg.sv
`default_nettype none
// ============================================================================
// Module      : adc_stream_pkg
// Description : Shared definitions for the ADC streaming path. Holds the
//               header magic, header field offsets, frame word indices,
//               the packer FSM state type and a sign-extension helper.
// Revision    : 1.0 - initial release
// ============================================================================
package adc_stream_pkg;

  // Default header magic byte
  localparam logic [7:0] ADC_MAGIC = 8'hA5;

  // Header word field offsets: {magic[31:24], n_ch[23:16], seq[15:0]}
  localparam int HDR_MAGIC_LSB = 24;
  localparam int HDR_NCH_LSB   = 16;
  localparam int HDR_SEQ_LSB   = 0;

  // Frame word indices: header first, channel c at DATA_IDX+c, check last
  localparam int HDR_IDX  = 0;
  localparam int DATA_IDX = 1;

  typedef enum logic [0:0] {
    ST_SYNC    = 1'b0,
    ST_COLLECT = 1'b1
  } state_e;

  // Index of the XOR check word for a frame of n_ch channels
  function automatic int check_idx(input int n_ch);
    return n_ch + 1;
  endfunction

  // Replicate bit (width-1) of raw into all bits above it
  function automatic logic [31:0] sign_extend(input logic [31:0] raw,
                                              input int          width);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      r[i] = (i < width) ? raw[i] : raw[width-1];
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/adc_frame_packer.sv
`default_nettype none
// ============================================================================
// Module      : adc_frame_packer
// Description : Collects one sample per channel (in channel order), sign-
//               extends each to 32 bits, prepends a header word and appends
//               an XOR check word. The complete frame is presented on
//               frame_words_packed together with a 1-cycle frame_valid.
// Ports       : clk, rst               - clock, synchronous active-high reset
//               enable                 - 0 drops any partial frame
//               sample_valid/ch/data   - sample beat from ADC capture
//               frame_valid            - 1-cycle pulse, frame complete
//               frame_words_packed     - word k at [32*k +: 32], held
//               seq_err                - 1-cycle pulse, channel order broken
//               busy                   - partial frame being collected
// Revision    : 1.0 - initial release
// ============================================================================
module adc_frame_packer
  import adc_stream_pkg::*;
#(
  parameter int         N_CH     = 8,
  parameter int         SAMPLE_W = 24,
  parameter logic [7:0] MAGIC    = ADC_MAGIC,
  localparam int        CH_W     = (N_CH <= 2) ? 1 : $clog2(N_CH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    sample_valid,
  input  logic [CH_W-1:0]         sample_ch,
  input  logic [SAMPLE_W-1:0]     sample_data,
  output logic                    frame_valid,
  output logic [32*(N_CH+2)-1:0]  frame_words_packed,
  output logic                    seq_err,
  output logic                    busy
);

  localparam int              CHECK_IDX = check_idx(N_CH);
  localparam logic [CH_W-1:0] LAST_CH   = CH_W'(N_CH - 1);

  state_e                   state_q, state_d;
  logic [CH_W-1:0]          exp_ch_q, exp_ch_d;
  logic [31:0]              acc_q, acc_d;
  logic [15:0]              seq_q, seq_d;
  logic [31:0]              col_q [N_CH];
  logic [31:0]              col_d [N_CH];
  logic [32*(N_CH+2)-1:0]   packed_q, packed_d;
  logic                     frame_valid_q, frame_valid_d;
  logic                     seq_err_q, seq_err_d;

  logic [31:0] hdr_word;
  logic [31:0] sx_word;
  logic [31:0] acc_next;
  logic        accept;
  logic        is_start;

  always_comb begin
    state_d       = state_q;
    exp_ch_d      = exp_ch_q;
    acc_d         = acc_q;
    seq_d         = seq_q;
    col_d         = col_q;
    packed_d      = packed_q;
    frame_valid_d = 1'b0;
    seq_err_d     = 1'b0;
    accept        = 1'b0;
    is_start      = 1'b0;

    hdr_word = '0;
    hdr_word[HDR_MAGIC_LSB +: 8]  = MAGIC;
    hdr_word[HDR_NCH_LSB   +: 8]  = 8'(N_CH);
    hdr_word[HDR_SEQ_LSB   +: 16] = seq_q;

    sx_word = sign_extend(32'(sample_data), SAMPLE_W);

    if (!enable) begin
      state_d = ST_SYNC;
    end else if (sample_valid) begin
      case (state_q)
        ST_SYNC: begin
          // Non-zero channels are dropped silently until frame alignment
          if (sample_ch == '0) begin
            accept   = 1'b1;
            is_start = 1'b1;
          end
        end
        ST_COLLECT: begin
          if (sample_ch == exp_ch_q) begin
            accept = 1'b1;
          end else if (sample_ch == '0) begin
            // Restart: flag the break but keep the beat as a fresh ch0
            accept    = 1'b1;
            is_start  = 1'b1;
            seq_err_d = 1'b1;
          end else begin
            seq_err_d = 1'b1;
            state_d   = ST_SYNC;
          end
        end
        default: state_d = ST_SYNC;
      endcase
    end

    // The header is folded in at ch0 so the check word is ready with the
    // final sample and no extra cycle is needed.
    acc_next = (is_start ? hdr_word : acc_q) ^ sx_word;

    if (accept) begin
      for (int i = 0; i < N_CH; i++) begin
        if (sample_ch == CH_W'(i)) col_d[i] = sx_word;
      end
      acc_d    = acc_next;
      exp_ch_d = sample_ch + 1'b1;
      if (sample_ch == LAST_CH) begin
        packed_d[32*HDR_IDX +: 32] = hdr_word;
        for (int i = 0; i < N_CH; i++) begin
          packed_d[32*(DATA_IDX+i) +: 32] = col_d[i];
        end
        packed_d[32*CHECK_IDX +: 32] = acc_next;
        frame_valid_d = 1'b1;
        seq_d         = seq_q + 16'd1;
        state_d       = ST_SYNC;
      end else begin
        state_d = ST_COLLECT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_SYNC;
      exp_ch_q      <= '0;
      acc_q         <= '0;
      seq_q         <= '0;
      packed_q      <= '0;
      frame_valid_q <= 1'b0;
      seq_err_q     <= 1'b0;
      for (int i = 0; i < N_CH; i++) col_q[i] <= '0;
    end else begin
      state_q       <= state_d;
      exp_ch_q      <= exp_ch_d;
      acc_q         <= acc_d;
      seq_q         <= seq_d;
      packed_q      <= packed_d;
      frame_valid_q <= frame_valid_d;
      seq_err_q     <= seq_err_d;
      for (int i = 0; i < N_CH; i++) col_q[i] <= col_d[i];
    end
  end

  assign frame_valid        = frame_valid_q;
  assign frame_words_packed = packed_q;
  assign seq_err            = seq_err_q;
  assign busy               = (state_q == ST_COLLECT);

endmodule
`default_nettype wire
